// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter width and palette for the display blocks.
// Colours are 8-bit RRRGGGBB.
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_H_TOTAL      = 800;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_DISP_START = 144;
    localparam int DEF_H_DISP_END   = 784;
    localparam int DEF_V_TOTAL      = 525;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_DISP_START = 35;
    localparam int DEF_V_DISP_END   = 515;

    typedef logic [7:0] colour_t;

    localparam colour_t BLACK = 8'h00;
    localparam colour_t WHITE = 8'hFF;
    localparam colour_t RED   = 8'hE0;
    localparam colour_t GREEN = 8'h1C;
    localparam colour_t BLUE  = 8'h03;
    localparam colour_t PINK  = 8'hE3;

    // Half-open window test lo <= val < hi on a counter value.
    function automatic logic in_range(input logic [COUNT_W-1:0] val, input int lo, input int hi);
        return (val >= COUNT_W'(lo)) && (val < COUNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: pix_en is high for one clk out of every CLK_DIV,
// on the last count of the divider.
module vga_pix_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic pix_en
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign pix_en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, sync and visible-window decode,
// plus line and frame strobes for the game logic.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_DISP_START = DEF_H_DISP_START,
    parameter int H_DISP_END   = DEF_H_DISP_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_DISP_START = DEF_V_DISP_START,
    parameter int V_DISP_END   = DEF_V_DISP_END
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               pix_en,
    output logic               line_tick,
    output logic               frame_tick
);

    logic               h_wrap;
    logic               v_wrap;
    logic [COUNT_W-1:0] h_nxt;
    logic [COUNT_W-1:0] v_nxt;

    vga_pix_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .pix_en (pix_en)
    );

    always_comb begin
        h_wrap = (hCount == COUNT_W'(H_TOTAL - 1));
        v_wrap = (vCount == COUNT_W'(V_TOTAL - 1));
        h_nxt  = h_wrap ? '0 : hCount + 1'b1;
        v_nxt  = vCount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vCount + 1'b1;
        end
    end

    // Decodes use the next-state counters so they line up with the counters they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            line_tick  <= pix_en && h_wrap;
            frame_tick <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hCount <= h_nxt;
                vCount <= v_nxt;
                hSync  <= (h_nxt >= COUNT_W'(H_SYNC));
                vSync  <= (v_nxt >= COUNT_W'(V_SYNC));
                bright <= in_range(h_nxt, H_DISP_START, H_DISP_END) &&
                          in_range(v_nxt, V_DISP_START, V_DISP_END);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, medium, tiny geometry)
// compared each cycle against a closed-form model driven by clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pe;
        logic       lt;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   k = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    // clocks elapsed since reset release; the model derives everything from this
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    logic [9:0] h0, v0, h1, v1, h2, v2;
    logic hs0, vs0, br0, pe0, lt0, ft0;
    logic hs1, vs1, br1, pe1, lt1, ft1;
    logic hs2, vs2, br2, pe2, lt2, ft2;
    obs_t obs0, obs1, obs2;
    assign obs0 = {h0, v0, hs0, vs0, br0, pe0, lt0, ft0};
    assign obs1 = {h1, v1, hs1, vs1, br1, pe1, lt1, ft1};
    assign obs2 = {h2, v2, hs2, vs2, br2, pe2, lt2, ft2};

    vga_timing_gen u_dflt (
        .clk(clk), .reset_n(reset_n), .hCount(h0), .vCount(v0), .hSync(hs0), .vSync(vs0),
        .bright(br0), .pix_en(pe0), .line_tick(lt0), .frame_tick(ft0)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(40), .H_SYNC(4), .H_DISP_START(6), .H_DISP_END(38),
        .V_TOTAL(30), .V_SYNC(2), .V_DISP_START(5), .V_DISP_END(27)
    ) u_med (
        .clk(clk), .reset_n(reset_n), .hCount(h1), .vCount(v1), .hSync(hs1), .vSync(vs1),
        .bright(br1), .pix_en(pe1), .line_tick(lt1), .frame_tick(ft1)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_DISP_START(3), .H_DISP_END(9),
        .V_TOTAL(6), .V_SYNC(1), .V_DISP_START(1), .V_DISP_END(5)
    ) u_tiny (
        .clk(clk), .reset_n(reset_n), .hCount(h2), .vCount(v2), .hSync(hs2), .vSync(vs2),
        .bright(br2), .pix_en(pe2), .line_tick(lt2), .frame_tick(ft2)
    );

    function automatic obs_t model(input int kk, input int cd, input int ht, input int hsw,
                                   input int hds, input int hde, input int vt, input int vsw,
                                   input int vds, input int vde);
        int   p, h, v;
        obs_t e;
        p    = kk / cd;
        h    = p % ht;
        v    = (p / ht) % vt;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= hsw);
        e.vs = (v >= vsw);
        e.br = (h >= hds) && (h < hde) && (v >= vds) && (v < vde);
        e.pe = ((kk % cd) == cd - 1);
        e.lt = (kk >= cd) && ((kk % cd) == 0) && (h == 0);
        e.ft = e.lt && (v == 0);
        return e;
    endfunction

    function automatic obs_t m_dflt(input int kk);
        return model(kk, 4, 800, 96, 144, 784, 525, 2, 35, 515);
    endfunction
    function automatic obs_t m_med(input int kk);
        return model(kk, 2, 40, 4, 6, 38, 30, 2, 5, 27);
    endfunction
    function automatic obs_t m_tiny(input int kk);
        return model(kk, 2, 10, 2, 3, 9, 6, 1, 1, 5);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%h want=%h", name, k, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act, exp);
    endtask

    // per-cycle model comparison plus period / bright-count measurements
    int last_lt = -1;
    int last_fm = -1;
    int last_ft = -1;
    int bcnt_m  = 0;
    int bcnt_t  = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("dflt", obs0, m_dflt(k));
            check("med",  obs1, m_med(k));
            check("tiny", obs2, m_tiny(k));
            if (!reset_n) begin
                last_lt = -1;
                last_fm = -1;
                last_ft = -1;
                bcnt_m  = 0;
                bcnt_t  = 0;
            end else begin
                if (lt0) begin
                    if (last_lt >= 0) check_int("line_period", k - last_lt, 3200);
                    last_lt = k;
                end
                if (ft1) begin
                    if (last_fm >= 0) begin
                        check_int("med_frame_period", k - last_fm, 2400);
                        check_int("med_bright_px", bcnt_m, 704);
                    end
                    last_fm = k;
                    bcnt_m  = 0;
                end
                if (ft2) begin
                    if (last_ft >= 0) begin
                        check_int("tiny_frame_period", k - last_ft, 120);
                        check_int("tiny_bright_px", bcnt_t, 24);
                    end
                    last_ft = k;
                    bcnt_t  = 0;
                end
                if (pe1 && br1) bcnt_m++;
                if (pe2 && br2) bcnt_t++;
            end
        end
    end

    task automatic zero_checks();
        check("rst_zero_dflt", obs0, '0);
        check("rst_zero_med",  obs1, '0);
        check("rst_zero_tiny", obs2, '0);
    endtask

    // release reset on a falling edge and confirm the first advance timing
    task automatic restart_check();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_int("first_pix_en", int'(pe0), 1);
        check_int("h_before_adv", int'(h0), 0);
        @(negedge clk);
        check_int("h_after_adv", int'(h0), 1);
        check_int("pix_en_drop", int'(pe0), 0);
    endtask

    initial begin
        obs_t want;
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;

        // hand-computed points that pin the model
        want = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        check("pin_first_pe", m_dflt(3), want);
        check_int("pin_h1_at_k4", int'(m_dflt(4).h), 1);
        want = '{10'd0, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        check("pin_line_wrap", m_dflt(3200), want);
        want = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        check("pin_frame_wrap", m_dflt(1680000), want);
        want = '{10'd144, 10'd35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        check("pin_bright_first", m_dflt(4 * (35 * 800 + 144)), want);
        check_int("pin_dark_143_35", int'(m_dflt(4 * (35 * 800 + 143) + 3).br), 0);
        check_int("pin_dark_144_34", int'(m_dflt(4 * (34 * 800 + 144)).br), 0);
        check_int("pin_dark_784_100", int'(m_dflt(4 * (100 * 800 + 784)).br), 0);
        check_int("pin_dark_200_515", int'(m_dflt(4 * (515 * 800 + 200)).br), 0);
        check_int("pin_hsync_95", int'(m_dflt(4 * 95).hs), 0);
        check_int("pin_hsync_96", int'(m_dflt(4 * 96).hs), 1);
        check_int("pin_vsync_v1", int'(m_dflt(4 * 800 * 1).vs), 0);
        check_int("pin_vsync_v2", int'(m_dflt(4 * 800 * 2).vs), 1);
        want = '{10'd9, 10'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        check("pin_tiny_last", m_tiny(119), want);

        repeat (5) @(negedge clk);
        zero_checks();
        restart_check();
        repeat (8 * 3200 + 100) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(500, 3000)) @(negedge clk);
            #($urandom_range(1, 3));
            reset_n = 1'b0;
            #1;
            zero_checks();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            restart_check();
        end

        repeat (6000) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
